// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: idle-high line, low start bit, LSB-first payload,
// optional odd/even parity and one or two stop bits, bit timing from an internal baud divider.
module uart_tx_param #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 CLK_TX,
  input  logic                 RST,
  input  logic [DATA_BITS-1:0] DATA,
  input  logic                 TRG,
  output logic                 TX,
  output logic                 BUSY,
  output logic                 DONE
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t                 state, state_nx;
  logic [CW-1:0]          baud_cnt, baud_nx;
  logic [BW-1:0]          bit_idx, bit_nx;
  logic                   stop_idx, stop_nx;
  logic [DATA_BITS-1:0]   data_buf, buf_nx;
  logic                   tx_nx, busy_nx, done_nx;
  logic                   baud_end;
  logic                   par_bit;

  assign baud_end = (baud_cnt == BAUD_LAST);
  assign par_bit  = (^data_buf) ^ ODD;

  always_ff @(posedge CLK_TX) begin
    if (RST) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      data_buf <= '0;
      TX       <= 1'b1;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_nx;
      bit_idx  <= bit_nx;
      stop_idx <= stop_nx;
      data_buf <= buf_nx;
      TX       <= tx_nx;
      BUSY     <= busy_nx;
      DONE     <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    baud_nx  = baud_cnt;
    bit_nx   = bit_idx;
    stop_nx  = stop_idx;
    buf_nx   = data_buf;
    done_nx  = 1'b0;
    tx_nx    = 1'b1;

    if (state != S_IDLE) begin
      baud_nx = baud_end ? '0 : baud_cnt + CW'(1);
    end

    case (state)
      S_IDLE: begin
        if (TRG) begin
          buf_nx   = DATA;
          state_nx = S_START;
          baud_nx  = '0;
        end
      end
      S_START: begin
        if (baud_end) begin
          state_nx = S_DATA;
          bit_nx   = '0;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          if (bit_idx == BIT_LAST) begin
            state_nx = (PARITY != 0) ? S_PAR : S_STOP;
            stop_nx  = 1'b0;
          end else begin
            bit_nx = bit_idx + BW'(1);
          end
        end
      end
      S_PAR: begin
        if (baud_end) begin
          state_nx = S_STOP;
          stop_nx  = 1'b0;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          if (stop_idx == STOP_LAST) begin
            state_nx = S_IDLE;
            done_nx  = 1'b1;
          end else begin
            stop_nx = stop_idx + 1'b1;
          end
        end
      end
      default: begin
        state_nx = S_IDLE;
        baud_nx  = '0;
      end
    endcase

    // TX is registered, so it is decoded from where the FSM is going next
    busy_nx = (state_nx != S_IDLE);
    case (state_nx)
      S_START: tx_nx = 1'b0;
      S_DATA:  tx_nx = buf_nx[bit_nx];
      S_PAR:   tx_nx = par_bit;
      default: tx_nx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: several parameter sets, each checked cycle by cycle against
// a per-cycle expected-waveform queue built from the frame format, plus directed checks.
module tb_uart_tx_param;

  localparam int unsigned NCFG = 5;
  localparam int unsigned CPB  = 4;
  localparam int unsigned DBS [NCFG] = '{8, 8, 8, 8, 5};
  localparam int unsigned PRS [NCFG] = '{0, 2, 1, 0, 2};
  localparam int unsigned SBS [NCFG] = '{1, 1, 1, 2, 1};
  localparam int unsigned D1  [NCFG] = '{'hA5, 'h07, 'h07, 'hFF, 'h13};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int fin    = 0;

  task automatic check(input int cfg, input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL cfg%0d %s: got %0h expected %0h at %0t", cfg, tag, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int unsigned DB = DBS[g];
    localparam int unsigned PR = PRS[g];
    localparam int unsigned SB = SBS[g];
    localparam int unsigned FL = CPB * (1 + DB + (PR != 0 ? 1 : 0) + SB);

    logic          rst, trg, tx, busy, done;
    logic [DB-1:0] data;

    uart_tx_param #(
      .DATA_BITS   (DB),
      .CLKS_PER_BIT(CPB),
      .PARITY      (PR),
      .STOP_BITS   (SB)
    ) dut (
      .CLK_TX(clk),
      .RST   (rst),
      .DATA  (data),
      .TRG   (trg),
      .TX    (tx),
      .BUSY  (busy),
      .DONE  (done)
    );

    // Reference: on acceptance, the whole frame is laid out as one TX value per cycle
    logic q[$];
    logic exp_tx = 1'b1, exp_busy = 1'b0, exp_done = 1'b0, armed = 1'b0;

    always @(posedge clk) begin
      if (rst) begin
        q.delete();
        exp_tx = 1'b1; exp_busy = 1'b0; exp_done = 1'b0; armed = 1'b1;
      end else if (exp_busy) begin
        if (q.size() > 0) begin
          exp_tx = q.pop_front(); exp_done = 1'b0;
        end else begin
          exp_tx = 1'b1; exp_busy = 1'b0; exp_done = 1'b1;
        end
      end else if (trg) begin
        int ones;
        ones = $countones(data);
        for (int c = 0; c < CPB; c++) q.push_back(1'b0);
        for (int b = 0; b < DB; b++)
          for (int c = 0; c < CPB; c++) q.push_back(((data >> b) & 1) != 0);
        if (PR != 0)
          for (int c = 0; c < CPB; c++)
            q.push_back(PR == 2 ? (ones % 2 == 1) : (ones % 2 == 0));
        for (int c = 0; c < CPB * SB; c++) q.push_back(1'b1);
        exp_tx = q.pop_front(); exp_busy = 1'b1; exp_done = 1'b0;
      end else begin
        exp_tx = 1'b1; exp_done = 1'b0;
      end
    end

    always @(negedge clk) begin
      if (armed) begin
        check(g, "tx", tx, exp_tx);
        check(g, "busy", busy, exp_busy);
        check(g, "done", done, exp_done);
      end
    end

    initial begin
      int nbusy, dcyc, ndone;
      rst = 1'b1; trg = 1'b0; data = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check(g, "rst_tx", tx, 1);
      check(g, "rst_busy", busy, 0);

      // Directed frame; a TRG pulse with zero data mid-frame must be ignored
      data = DB'(D1[g]); trg = 1'b1;
      @(negedge clk);
      data = '0; nbusy = 0; dcyc = 0;
      for (int i = 0; i < 400; i++) begin
        trg = (i == 10);
        if (busy) nbusy++;
        if (done) begin dcyc = i + 1; break; end
        @(negedge clk);
      end
      check(g, "busy_len", nbusy, FL);
      check(g, "done_cycle", dcyc, FL + 1);

      // Back-to-back: TRG in the DONE cycle starts the next frame immediately
      trg = 1'b1; data = DB'('h3C);
      @(negedge clk);
      trg = 1'b0;
      check(g, "b2b_start_tx", tx, 0);
      check(g, "b2b_busy", busy, 1);
      for (int i = 0; i < 400 && exp_busy; i++) @(negedge clk);
      check(g, "idle_after_b2b", busy, 0);
      @(negedge clk);

      // Reset at cycle 15 of a frame
      data = DB'('hA5); trg = 1'b1;
      @(negedge clk);
      trg = 1'b0;
      repeat (14) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check(g, "abort_tx", tx, 1);
      check(g, "abort_busy", busy, 0);
      ndone = 0;
      for (int i = 0; i < 60; i++) begin
        if (done) ndone++;
        @(negedge clk);
      end
      check(g, "abort_no_done", ndone, 0);
      data = DB'('h81); trg = 1'b1;
      @(negedge clk);
      trg = 1'b0;
      for (int i = 0; i < 400 && exp_busy; i++) @(negedge clk);
      check(g, "idle_after_81", busy, 0);

      // Random TRG/DATA with occasional reset
      for (int i = 0; i < 800; i++) begin
        trg  = ($urandom % 6) == 0;
        data = DB'($urandom);
        rst  = ($urandom % 250) == 0;
        @(negedge clk);
      end
      rst = 1'b0; trg = 1'b0;

      // TRG held high: consecutive frames, DATA changing every cycle
      trg = 1'b1;
      for (int i = 0; i < 3 * (FL + 1); i++) begin
        data = DB'($urandom);
        @(negedge clk);
      end
      trg = 1'b0;
      for (int i = 0; i < 400 && exp_busy; i++) @(negedge clk);
      check(g, "idle_at_end", busy, 0);
      repeat (2) @(negedge clk);
      fin++;
    end
  end

  initial begin
    for (int i = 0; i < 30000 && fin < NCFG; i++) @(negedge clk);
    check(-1, "all_configs_finished", fin, NCFG);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
